// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
//   Pattern sequencer for a 4-LED bank. It divides clk into a programmable
//   step period and walks the LEDs through one of five patterns:
//   walk-left, walk-right, ping-pong, blink and count.
//
//   Configuration uses a valid/ready port. A transfer happens when
//   cfg_valid && cfg_ready at a posedge. The level input `run` starts and
//   pauses the sequence. All outputs are registered.
//
//   Optional feature (compile macro LED_PWM_EN):
//     Adds the input pwm_duty[3:0] and a free-running 4-bit PWM counter.
//     The registered LED drive is then gated by (pwm_cnt < pwm_duty).
//
// Parameters:
//   CLK_DIV   step period in clk cycles after reset
//   DEF_MODE  pattern mode after reset
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   run         1 = sequence advances, 0 = pause
//   cfg_valid   config request
//   cfg_ready   config accept (low only during the LOAD cycle)
//   cfg_mode    pattern mode 0..4; values 5..7 are latched as 0
//   cfg_period  step period in cycles; 0 is latched as 1
//   pwm_duty    (LED_PWM_EN only) LED brightness duty, 0..15
//   led_data    registered LED drive, bit0 = LED0
//   step        one-cycle pulse aligned with each pattern advance
//   mode        currently latched mode
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter logic [31:0] CLK_DIV  = 32'd50_000_000,
  parameter logic [2:0]  DEF_MODE = 3'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_mode,
  input  logic [31:0] cfg_period,
`ifdef LED_PWM_EN
  input  logic [3:0]  pwm_duty,
`endif
  output logic [3:0]  led_data,
  output logic        step,
  output logic [2:0]  mode
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [31:0] period_q, period_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  pat_q, pat_d;
  logic [2:0]  mode_d;
  logic        step_d;
  logic        xfer;

  // Pattern that a mode starts from after LOAD.
  function automatic logic [3:0] start_pat(input logic [2:0] m);
    case (m)
      3'd1:    return 4'b1000;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  assign xfer = cfg_valid && cfg_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    period_d = period_q;
    timer_d  = timer_q;
    pat_d    = pat_q;
    mode_d   = mode;
    step_d   = 1'b0;

    // A cfg transfer is accepted in IDLE, RUN and HOLD. It always takes
    // priority over an advance in the same cycle.
    if (xfer && state_q != LOAD) begin
      state_d  = LOAD;
      mode_d   = (cfg_mode > 3'd4) ? 3'd0 : cfg_mode;
      period_d = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
    end

    case (state_q)
      IDLE: begin
        pat_d   = 4'b0000;
        timer_d = 32'd0;
        if (!xfer && run) state_d = LOAD;
      end
      LOAD: begin
        pat_d   = start_pat(mode);
        timer_d = 32'd0;
        dir_d   = DIR_UP;
        state_d = run ? RUN : HOLD;
      end
      RUN: begin
        if (!xfer) begin
          if (!run) begin
            state_d = HOLD;
          end else if (timer_q == period_q - 32'd1) begin
            timer_d = 32'd0;
            step_d  = 1'b1;
            case (mode)
              3'd0: pat_d = {pat_q[2:0], pat_q[3]};
              3'd1: pat_d = {pat_q[0], pat_q[3:1]};
              3'd2: begin
                // Ping-pong turns around at the ends without repeating them.
                if (dir_q == DIR_UP) begin
                  if (pat_q == 4'b1000) begin
                    pat_d = 4'b0100;
                    dir_d = DIR_DOWN;
                  end else begin
                    pat_d = pat_q << 1;
                  end
                end else begin
                  if (pat_q == 4'b0001) begin
                    pat_d = 4'b0010;
                    dir_d = DIR_UP;
                  end else begin
                    pat_d = pat_q >> 1;
                  end
                end
              end
              3'd3:    pat_d = ~pat_q;
              3'd4:    pat_d = pat_q + 4'd1;
              default: pat_d = pat_q;
            endcase
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
      end
      HOLD: begin
        // The timer stays frozen, so counting resumes where it stopped.
        if (!xfer && run) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_q;
  logic [3:0] led_d;
  assign led_d = pat_d & {4{pwm_cnt_q < pwm_duty}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pwm_cnt_q <= 4'd0;
    else       pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end
`else
  logic [3:0] led_d;
  assign led_d = pat_d;
`endif

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      period_q  <= CLK_DIV;
      timer_q   <= 32'd0;
      pat_q     <= 4'b0000;
      mode      <= DEF_MODE;
      led_data  <= 4'b0000;
      step      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      period_q  <= period_d;
      timer_q   <= timer_d;
      pat_q     <= pat_d;
      mode      <= mode_d;
      led_data  <= led_d;
      step      <= step_d;
      // cfg_ready is registered, so it reflects the state being entered.
      cfg_ready <= (state_d != LOAD);
    end
  end

endmodule
